// File: rtl/float_adder_if.sv
// Operand/result bundle for the binary16 adder.
// The master drives the operands; the slave returns the sum and the status flags.
interface float_adder_if;
  logic [15:0] num1;
  logic [15:0] num2;
  logic [15:0] result;
  logic        overflow;
  logic        zero;
  logic        nan;
  logic        precisionLost;

  modport master (
    output num1, num2,
    input  result, overflow, zero, nan, precisionLost
  );

  modport slave (
    input  num1, num2,
    output result, overflow, zero, nan, precisionLost
  );
endinterface

// File: rtl/float_adder.sv
// binary16 adder/subtractor: truncating toward zero, with overflow/zero/nan/inexact flags.
// Combinational datapath followed by one registered output stage.
module float_adder (
  input  logic          clk,
  input  logic          rst,
  float_adder_if.slave  bus
);
  localparam int MANT_W  = 11;
  localparam int ALIGN_W = 32;
  localparam int SUM_W   = MANT_W + ALIGN_W + 1;

  logic        sign_a, sign_b;
  logic [4:0]  exp_a, exp_b;
  logic [9:0]  frac_a, frac_b;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic [4:0]  eff_a, eff_b;
  logic [10:0] mant_a, mant_b;

  logic              a_ge_b;
  logic              sign_big;
  logic [4:0]        eff_big, exp_diff;
  logic [10:0]       mant_big, mant_small;
  logic [SUM_W-1:0]  big_al, small_al, sum;
  logic              carry;
  logic [5:0]        lz, sh, max_sh;
  logic [SUM_W-2:0]  norm;
  logic [5:0]        exp_n, exp_field;
  logic              lost;

  logic [15:0] result_p0, result_p1;
  logic        ovf_p0, zero_p0, nan_p0, lost_p0;
  logic        ovf_p1, zero_p1, nan_p1, lost_p1;

  // Leading-zero count over the 43-bit aligned magnitude (carry bit excluded).
  function automatic logic [5:0] lzc(input logic [SUM_W-2:0] v);
    logic [5:0] n;
    n = 6'd43;
    for (int i = 0; i < SUM_W - 1; i++)
      if (v[i]) n = 6'(42 - i);
    return n;
  endfunction

  // Truncation toward zero is simply dropping everything below the 10 kept fraction bits.
  function automatic logic [15:0] trunc_pack(input logic s, input logic [4:0] e,
                                             input logic [SUM_W-2:0] m);
    return {s, e, m[41:32]};
  endfunction

  function automatic logic [15:0] sat_inf(input logic s);
    return {s, 5'h1F, 10'h000};
  endfunction

  assign sign_a = bus.num1[15];
  assign exp_a  = bus.num1[14:10];
  assign frac_a = bus.num1[9:0];
  assign sign_b = bus.num2[15];
  assign exp_b  = bus.num2[14:10];
  assign frac_b = bus.num2[9:0];

  assign nan_a  = (exp_a == 5'h1F) && (frac_a != 10'd0);
  assign nan_b  = (exp_b == 5'h1F) && (frac_b != 10'd0);
  assign inf_a  = (exp_a == 5'h1F) && (frac_a == 10'd0);
  assign inf_b  = (exp_b == 5'h1F) && (frac_b == 10'd0);

  // Subnormals behave as exponent 1 with no hidden bit.
  assign eff_a  = (exp_a == 5'd0) ? 5'd1 : exp_a;
  assign eff_b  = (exp_b == 5'd0) ? 5'd1 : exp_b;
  assign mant_a = {exp_a != 5'd0, frac_a};
  assign mant_b = {exp_b != 5'd0, frac_b};

  // Stage p0: align, add/subtract, normalize, classify
  always_comb begin
    a_ge_b     = {eff_a, mant_a} >= {eff_b, mant_b};
    sign_big   = a_ge_b ? sign_a : sign_b;
    eff_big    = a_ge_b ? eff_a  : eff_b;
    exp_diff   = a_ge_b ? (eff_a - eff_b) : (eff_b - eff_a);
    mant_big   = a_ge_b ? mant_a : mant_b;
    mant_small = a_ge_b ? mant_b : mant_a;

    // 32 guard positions below the mantissa hold the largest possible shift exactly,
    // so the discarded-bit test below sees every bit that alignment pushed out.
    big_al   = {1'b0, mant_big,   {ALIGN_W{1'b0}}};
    small_al = {1'b0, mant_small, {ALIGN_W{1'b0}}} >> exp_diff;
    sum      = (sign_a ^ sign_b) ? (big_al - small_al) : (big_al + small_al);
    carry    = sum[SUM_W-1];

    lz     = lzc(sum[SUM_W-2:0]);
    max_sh = {1'b0, eff_big} - 6'd1;
    sh     = (lz > max_sh) ? max_sh : lz;

    if (carry) begin
      norm  = sum[SUM_W-1:1];
      exp_n = {1'b0, eff_big} + 6'd1;
      lost  = |sum[ALIGN_W:0];
    end else begin
      norm  = sum[SUM_W-2:0] << sh;
      exp_n = {1'b0, eff_big} - sh;
      lost  = |norm[ALIGN_W-1:0];
    end
    // Without a hidden bit after the shift the result is subnormal.
    exp_field = norm[SUM_W-2] ? exp_n : 6'd0;

    result_p0 = 16'h0000;
    ovf_p0    = 1'b0;
    zero_p0   = 1'b0;
    nan_p0    = 1'b0;
    lost_p0   = 1'b0;
    if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
      result_p0 = 16'h7E00;
      nan_p0    = 1'b1;
    end else if (inf_a) begin
      result_p0 = bus.num1;
    end else if (inf_b) begin
      result_p0 = bus.num2;
    end else if (sum == '0) begin
      zero_p0 = 1'b1;
    end else if (exp_field >= 6'd31) begin
      result_p0 = sat_inf(sign_big);
      ovf_p0    = 1'b1;
      lost_p0   = lost;
    end else begin
      result_p0 = trunc_pack(sign_big, exp_field[4:0], norm);
      lost_p0   = lost;
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= 16'h0000;
      ovf_p1    <= 1'b0;
      zero_p1   <= 1'b0;
      nan_p1    <= 1'b0;
      lost_p1   <= 1'b0;
    end else begin
      result_p1 <= result_p0;
      ovf_p1    <= ovf_p0;
      zero_p1   <= zero_p0;
      nan_p1    <= nan_p0;
      lost_p1   <= lost_p0;
    end
  end

  assign bus.result        = result_p1;
  assign bus.overflow      = ovf_p1;
  assign bus.zero          = zero_p1;
  assign bus.nan           = nan_p1;
  assign bus.precisionLost = lost_p1;
endmodule

// File: tb/tb_float_adder.sv
// Self-checking bench for float_adder: directed vectors, specials, reset and random
// operands compared against a real-number reference model of truncating binary16 addition.
module tb_float_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  float_adder_if bus();

  float_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real m;
    if (h[14:10] == 5'd0) m = $itor({22'd0, h[9:0]}) * pow2(-24);
    else                  m = $itor({21'd0, 1'b1, h[9:0]}) * pow2(int'(h[14:10]) - 25);
    return h[15] ? -m : m;
  endfunction

  // Expected {result, overflow, zero, nan, precisionLost}; all binary16 sums are exact in a real.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic na, nb, ia, ib, sg, ls;
    real  s, mag, unit, q;
    int   e;
    longint m;
    na = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    nb = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    ia = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    ib = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    if (na || nb || (ia && ib && a[15] != b[15])) return {16'h7E00, 4'b0010};
    if (ia) return {a, 4'b0000};
    if (ib) return {b, 4'b0000};
    s = h2r(a) + h2r(b);
    if (s == 0.0) return {16'h0000, 4'b0100};
    sg  = (s < 0.0);
    mag = sg ? -s : s;
    if (mag < pow2(-14)) begin
      unit = pow2(-24);
      q = $floor(mag / unit);
      m = longint'(q);
      ls = (q * unit != mag);
      return {sg, 5'd0, m[9:0], 3'b000, ls};
    end
    e = 16;
    while (mag < pow2(e)) e--;
    unit = pow2(e - 10);
    q = $floor(mag / unit);
    m = longint'(q);
    ls = (q * unit != mag);
    if (e >= 16) return {sg, 5'h1F, 10'h000, 3'b100, ls};
    return {sg, 5'(e + 15), m[9:0], 3'b000, ls};
  endfunction

  function automatic logic [15:0] pick();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 4))
      0: r[14:10] = 5'd0;
      1: r[14:10] = 5'($urandom_range(27, 30));
      2: r[14:10] = 5'($urandom_range(13, 16));
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [19:0] observed();
    return {bus.result, bus.overflow, bus.zero, bus.nan, bus.precisionLost};
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.num1 = a;
    bus.num2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] exp_v;
    bus.num1 = 16'h3C00;
    bus.num2 = 16'h4000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (observed() !== 20'h0) begin
      fails++;
      $display("FAIL reset_initial got=%h exp=%h", observed(), 20'h0);
    end
    @(negedge clk); rst = 1'b0;
    drive(16'h3C00, 16'h4000);
    exp_v = model(16'h3C00, 16'h4000);
    tests++;
    if (observed() !== exp_v || exp_v[19:4] !== 16'h4200) begin
      fails++;
      $display("FAIL after_reset_release got=%h exp=%h", observed(), exp_v);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (observed() !== 20'h0) begin
      fails++;
      $display("FAIL reset_midstream got=%h exp=%h", observed(), 20'h0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (observed() !== exp_v) begin
      fails++;
      $display("FAIL reset_release_latency got=%h exp=%h", observed(), exp_v);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [12] = '{16'h54a5, 16'h00e0, 16'hc0b0, 16'h29a8, 16'h00b8, 16'h10a0,
                             16'he49d, 16'h7bff, 16'h44ff, 16'h7c00, 16'h0001, 16'h8001};
    logic [15:0] vb [12] = '{16'h1cc0, 16'h5060, 16'h1cc0, 16'he1f9, 16'h0080, 16'h106c,
                             16'h649d, 16'h7bff, 16'h7cff, 16'h4b83, 16'h03ff, 16'h0002};
    logic [19:0] ve [12] = '{{16'h54a5, 4'b0001}, {16'h5060, 4'b0001}, {16'hc0ad, 4'b0001},
                             {16'he1f8, 4'b0001}, {16'h0138, 4'b0000}, {16'h1486, 4'b0000},
                             {16'h0000, 4'b0100}, {16'h7c00, 4'b1000}, {16'h7e00, 4'b0010},
                             {16'h7c00, 4'b0000}, {16'h0400, 4'b0000}, {16'h0001, 4'b0000}};
    for (int i = 0; i < 12; i++) begin
      drive(va[i], vb[i]);
      tests++;
      if (observed() !== ve[i]) begin
        fails++;
        $display("FAIL directed_%0d a=%h b=%h got=%h exp=%h", i, va[i], vb[i], observed(), ve[i]);
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] va [6] = '{16'h7c00, 16'hfc00, 16'h7c00, 16'h3c00, 16'hfe01, 16'h8000};
    logic [15:0] vb [6] = '{16'hfc00, 16'hfc00, 16'h7c00, 16'hfc00, 16'h7c00, 16'h0000};
    logic [19:0] ve [6] = '{{16'h7e00, 4'b0010}, {16'hfc00, 4'b0000}, {16'h7c00, 4'b0000},
                            {16'hfc00, 4'b0000}, {16'h7e00, 4'b0010}, {16'h0000, 4'b0100}};
    for (int i = 0; i < 6; i++) begin
      drive(va[i], vb[i]);
      tests++;
      if (observed() !== ve[i]) begin
        fails++;
        $display("FAIL special_%0d a=%h b=%h got=%h exp=%h", i, va[i], vb[i], observed(), ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [19:0] exp_v;
    for (int i = 0; i < 600; i++) begin
      a = pick();
      b = pick();
      if ($urandom_range(0, 3) == 0) b[14:10] = a[14:10] + 5'($urandom_range(0, 2));
      drive(a, b);
      exp_v = model(a, b);
      tests++;
      if (observed() !== exp_v) begin
        fails++;
        $display("FAIL random a=%h b=%h got=%h exp=%h", a, b, observed(), exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b;
    logic [19:0] exp_v;
    for (int i = 0; i < 200; i++) begin
      a = pick();
      b = {~a[15], a[14:10], 10'($urandom)};
      drive(a, b);
      exp_v = model(a, b);
      tests++;
      if (observed() !== exp_v) begin
        fails++;
        $display("FAIL b2b_cancel a=%h b=%h got=%h exp=%h", a, b, observed(), exp_v);
      end
      bus.num1 = ~a;
      #2;
      tests++;
      if (observed() !== exp_v) begin
        fails++;
        $display("FAIL b2b_hold a=%h b=%h got=%h exp=%h", a, b, observed(), exp_v);
      end
    end
  endtask

  initial begin
    bus.num1 = 16'h0000;
    bus.num2 = 16'h0000;
    test_reset();
    test_directed();
    test_specials();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
